sort_ctrl: RTL and testbench
============================

// Module: sort_ctrl
// PURPOSE
//  Sequencer that shares one 8-bit magnitude comparator to sort a block of DEPTH bytes.
//  It loads a block over a valid/ready input stream, bubble-sorts the block in an
//  internal buffer one comparison per clock, then drains the result over a valid/ready
//  output stream. It sits between a byte producer and a consumer that needs ordered data.
// PARAMETERS
//  DEPTH   8    bytes per block; legal range 2..16
//  CNT_W   8    width of cmp_count; must hold DEPTH*(DEPTH-1)/2
// PORTS
//  clk        in   1      single clock; all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      in_data is valid this cycle
//  in_ready   out  1      block accepts a byte this cycle (high only in LOAD)
//  in_data    in   8      unsigned byte
//  desc       in   1      sort order, sampled on the last LOAD handshake: 0=ascending, 1=descending
//  out_valid  out  1      out_data is valid (high only in DRAIN)
//  out_ready  in   1      consumer takes out_data this cycle
//  out_data   out  8      sorted byte, smallest first (ascending) or largest first (descending)
//  busy       out  1      high in SORT and DRAIN
//  cmp_count  out  CNT_W  comparisons used by the last completed sort; held until the next SORT ends
// BEHAVIOUR
//  Reset: state=LOAD; wr_ptr, rd_ptr, pass and j = 0; cmp_count=0; buffer contents don't-care.
//   Outputs during and after reset: in_ready=1, out_valid=0, busy=0, out_data=0.
//  States: LOAD -> SORT -> DRAIN -> LOAD.
//  LOAD:
//   - Each cycle with in_valid&in_ready: buf[wr_ptr] <= in_data and wr_ptr increments.
//   - On the DEPTH-th handshake: latch desc, clear pass/j/swapped, enter SORT next cycle.
//  SORT: one comparison per cycle, with cmp A=buf[j] and B=buf[j+1].
//   - Swap when (greater & !desc) | (lesser & desc).
//   - equal never swaps; the sort is stable.
//   - A swap sets the swapped flag, and a comparison counter increments every SORT cycle.
//   - j runs 0..DEPTH-2-pass. At the end of a pass:
//     - if no swap happened, or pass == DEPTH-2: go to DRAIN, load cmp_count, rd_ptr=0;
//     - otherwise pass++, j=0, swapped=0.
//   - Latency: best case (already ordered) DEPTH-1 cycles; worst case DEPTH*(DEPTH-1)/2 cycles.
//  DRAIN:
//   - out_valid=1 and out_data=buf[rd_ptr] (registered read, stable while stalled).
//   - On out_valid&out_ready: rd_ptr increments.
//   - On the DEPTH-th handshake: go to LOAD with wr_ptr=0; out_valid drops the next cycle.
//  Backpressure: in LOAD, in_valid low inserts bubbles with no state change.
//   In DRAIN, out_ready low holds out_data and out_valid.
//  in_valid is ignored outside LOAD; no data is lost because in_ready=0 there.
//  A reset asserted mid-block (any state) discards the block. The next block restarts at wr_ptr=0.
//  Input and output streams never overlap: in_ready and out_valid are never both 1.
//  All arithmetic is unsigned 8-bit. Pointers are $clog2(DEPTH) bits wide and never wrap past DEPTH-1.
// STRUCTURE
//  Shared package: state encoding (ST_LOAD, ST_SORT, ST_DRAIN) and the DEPTH/CNT_W legality checks.
//  One sub-module, cmp_mag: a combinational 8-bit unsigned comparator with one-hot
//   greater/lesser/equal outputs. It is instanced exactly once and fed from the buffer mux.
//  Top level contains the FSM, pointers, DEPTHx8 register buffer, swap logic and counter.
// TESTING
//  1. Reset, load 5,3,8,1,9,2,7,4 (asc) -> drain 1,2,3,4,5,7,8,9.
//  2. Load 1..8 (asc), already sorted -> cmp_count=7, drain 1..8.
//     Load 8..1 (asc) -> cmp_count=28, drain 1..8.
//  3. Load 0x00,0xFF,0x80,0x7F,0x80,0x01,0xFE,0x00 (desc)
//     -> drain FF,FE,80,80,7F,01,00,00 (unsigned compare, duplicates kept).
//  4. Random in_valid gaps and out_ready stalls on 20 random blocks -> output matches a reference sort.
//     out_data is stable during stalls; in_ready&out_valid never both 1.
//  5. Assert rst_n low after 3 loaded bytes, and again mid-SORT
//     -> outputs return to reset values immediately; the next full block sorts correctly.
//  6. All bytes 0x42 -> cmp_count=7, drain eight 0x42; busy high from SORT entry to the last drain handshake.

Source files
------------

// File: rtl/sort_ctrl_pkg.sv
// Shared definitions for the sort_ctrl block.
//   - state_t      : FSM encoding (ST_LOAD, ST_SORT, ST_DRAIN)
//   - depth_ok()   : legal block sizes
//   - cnt_ok()     : cmp_count wide enough for a worst-case sort of DEPTH bytes
package sort_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int unsigned DEPTH_MIN = 2;
    localparam int unsigned DEPTH_MAX = 16;

    function automatic bit depth_ok(input int unsigned depth);
        return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
    endfunction

    // Worst case is a full bubble sort: depth*(depth-1)/2 comparisons.
    function automatic bit cnt_ok(input int unsigned depth, input int unsigned cnt_w);
        return (cnt_w >= 1) && (cnt_w <= 31) &&
               ((depth * (depth - 1) / 2) < (32'd1 << cnt_w));
    endfunction

endpackage

// File: rtl/cmp_mag.sv
// Combinational 8-bit unsigned magnitude comparator.
// Ports:
//   a, b     in   8   operands
//   greater  out  1   a > b
//   lesser   out  1   a < b
//   equal    out  1   a == b
// Exactly one of greater/lesser/equal is high.
module cmp_mag (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       greater,
    output logic       lesser,
    output logic       equal
);

    always_comb begin
        greater = (a > b);
        lesser  = (a < b);
        equal   = (a == b);
    end

endmodule

// File: rtl/sort_ctrl.sv
// Block sorter: loads DEPTH bytes over a valid/ready stream, bubble-sorts them in place
// using a single shared comparator (one comparison per clock), then drains the sorted
// block over a valid/ready output stream.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake (in_ready high only in LOAD)
//   in_data              input byte
//   desc                 sort order, sampled on the last load handshake (1 = descending)
//   out_valid/out_ready  output handshake (out_valid high only in DRAIN)
//   out_data             sorted byte, 0 outside DRAIN
//   busy                 high in SORT and DRAIN
//   cmp_count            comparisons used by the last completed sort
module sort_ctrl
    import sort_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             desc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             busy,
    output logic [CNT_W-1:0] cmp_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PASS_LAST = PTR_W'(DEPTH - 2);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("sort_ctrl: DEPTH must be in 2..16");
    end
    if (!cnt_ok(DEPTH, CNT_W)) begin : g_bad_cnt_w
        $error("sort_ctrl: CNT_W too narrow for DEPTH*(DEPTH-1)/2");
    end

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q, j_q, pass_q;
    logic               swapped_q, desc_q;
    logic [CNT_W-1:0]   cnt_q, cmp_count_q;
    logic [7:0]         mem_q [DEPTH];

    logic [PTR_W-1:0]   j_nxt, j_last;
    logic [7:0]         cmp_a, cmp_b;
    logic               cmp_gt, cmp_lt, cmp_eq;
    logic               swap, pass_end, sort_done;
    logic               load_hs, load_last, drain_hs, drain_last;

    // Comparator operands come from the buffer at the current inner index.
    assign j_nxt  = j_q + PTR_W'(1);
    assign j_last = PASS_LAST - pass_q;
    assign cmp_a  = mem_q[j_q];
    assign cmp_b  = mem_q[j_nxt];

    cmp_mag u_cmp (
        .a       (cmp_a),
        .b       (cmp_b),
        .greater (cmp_gt),
        .lesser  (cmp_lt),
        .equal   (cmp_eq)
    );

    // Equal elements are never swapped, which keeps the sort stable.
    assign swap = (state_q == ST_SORT) && !cmp_eq &&
                  ((cmp_gt && !desc_q) || (cmp_lt && desc_q));

    assign pass_end  = (state_q == ST_SORT) && (j_q == j_last);
    // Finished when a whole pass made no swap, or the final pass has run.
    assign sort_done = pass_end && (!(swapped_q || swap) || (pass_q == PASS_LAST));

    assign load_hs    = in_valid && in_ready;
    assign load_last  = load_hs && (wr_ptr_q == LAST_IDX);
    assign drain_hs   = out_valid && out_ready;
    assign drain_last = drain_hs && (rd_ptr_q == LAST_IDX);

    // ---------------------------------------------------------------- FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD:  if (load_last)  state_d = ST_SORT;
            ST_SORT:  if (sort_done)  state_d = ST_DRAIN;
            ST_DRAIN: if (drain_last) state_d = ST_LOAD;
            default:                  state_d = ST_LOAD;
        endcase
    end

    // ---------------------------------------------------------------- FSM: outputs
    always_comb begin
        in_ready  = (state_q == ST_LOAD);
        out_valid = (state_q == ST_DRAIN);
        busy      = (state_q == ST_SORT) || (state_q == ST_DRAIN);
        out_data  = (state_q == ST_DRAIN) ? mem_q[rd_ptr_q] : 8'h00;
        cmp_count = cmp_count_q;
    end

    // ---------------------------------------------------------------- control datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            j_q         <= '0;
            pass_q      <= '0;
            swapped_q   <= 1'b0;
            desc_q      <= 1'b0;
            cnt_q       <= '0;
            cmp_count_q <= '0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    if (load_hs) begin
                        wr_ptr_q <= load_last ? '0 : wr_ptr_q + PTR_W'(1);
                    end
                    if (load_last) begin
                        desc_q    <= desc;
                        pass_q    <= '0;
                        j_q       <= '0;
                        swapped_q <= 1'b0;
                        cnt_q     <= '0;
                    end
                end
                ST_SORT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (sort_done) begin
                        cmp_count_q <= cnt_q + CNT_W'(1);
                        rd_ptr_q    <= '0;
                    end else if (pass_end) begin
                        pass_q    <= pass_q + PTR_W'(1);
                        j_q       <= '0;
                        swapped_q <= 1'b0;
                    end else begin
                        j_q       <= j_nxt;
                        swapped_q <= swapped_q || swap;
                    end
                end
                ST_DRAIN: begin
                    if (drain_hs) begin
                        rd_ptr_q <= drain_last ? '0 : rd_ptr_q + PTR_W'(1);
                    end
                    if (drain_last) begin
                        wr_ptr_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------- buffer (no reset)
    always_ff @(posedge clk) begin
        if (load_hs) begin
            mem_q[wr_ptr_q] <= in_data;
        end else if (swap) begin
            mem_q[j_q]   <= cmp_b;
            mem_q[j_nxt] <= cmp_a;
        end
    end

endmodule

// File: tb/tb_sort_ctrl.sv
// Self-checking bench for sort_ctrl: loaded blocks push their reference-sorted bytes to a
// scoreboard queue; the drain task pops and compares as the DUT emits them.
module tb_sort_ctrl;

    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, desc;
    logic       out_valid, out_ready, busy;
    logic [7:0] in_data, out_data, cmp_count;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] sb [$];
    int         first_valid;

    always #5 clk = ~clk;

    sort_ctrl #(
        .DEPTH (DEPTH),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .desc      (desc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .cmp_count (cmp_count)
    );

    // Streams must never be open at the same time.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_tests++;
            if (in_ready && out_valid) begin
                n_fail++;
                $display("FAIL overlap: in_ready=%b out_valid=%b required not both 1",
                         in_ready, out_valid);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: stable insertion sort.
    task automatic ref_sort(input logic [7:0] a [$], input bit d, output logic [7:0] r [$]);
        r = a;
        for (int i = 1; i < r.size(); i++) begin
            logic [7:0] k;
            int m;
            k = r[i];
            m = i - 1;
            while (m >= 0 && (d ? (r[m] < k) : (r[m] > k))) begin
                r[m+1] = r[m];
                m--;
            end
            r[m+1] = k;
        end
    endtask

    task automatic load_block(input logic [7:0] blk [$], input bit d, input bit gaps);
        logic [7:0] exp [$];
        for (int i = 0; i < blk.size(); i++) begin
            bit hs;
            int w;
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    tick();
                end
            end
            in_valid = 1'b1;
            in_data  = blk[i];
            // desc only matters on the final handshake
            desc     = (i == blk.size() - 1) ? d : 1'($urandom_range(0, 1));
            hs = 1'b0;
            w  = 0;
            while (!hs && w < 50) begin
                @(negedge clk);
                hs = in_ready;
                tick();
                w++;
            end
            if (!hs) begin
                n_tests++;
                n_fail++;
                $display("FAIL load_timeout: byte %0d not accepted, required in_ready=1", i);
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        desc     = ~d;
        ref_sort(blk, d, exp);
        foreach (exp[i]) sb.push_back(exp[i]);
    endtask

    task automatic drain_block(input bit stall);
        int         got = 0;
        int         cyc = 0;
        bit         held_v = 1'b0;
        logic [7:0] held = 8'h00;
        first_valid = -1;
        while (got < int'(DEPTH) && cyc < 300) begin
            out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            cyc++;
            n_tests++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_high: busy=%b required 1 (cycle %0d)", busy, cyc);
            end
            if (out_valid === 1'b1) begin
                if (first_valid < 0) first_valid = cyc;
                if (held_v) begin
                    n_tests++;
                    if (out_data !== held) begin
                        n_fail++;
                        $display("FAIL stall_stable: out_data=%h required %h", out_data, held);
                    end
                end
                if (out_ready) begin
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_empty: out_data=%h with no expected byte", out_data);
                    end else begin
                        logic [7:0] e;
                        e = sb.pop_front();
                        if (out_data !== e) begin
                            n_fail++;
                            $display("FAIL drain_data[%0d]: out_data=%h required %h",
                                     got, out_data, e);
                        end
                    end
                    got++;
                    held_v = 1'b0;
                end else begin
                    held   = out_data;
                    held_v = 1'b1;
                end
            end
            tick();
        end
        out_ready = 1'b0;
        n_tests++;
        if (got < int'(DEPTH)) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d bytes required %0d", got, DEPTH);
        end else if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL after_drain: busy=%b out_valid=%b in_ready=%b required 0,0,1",
                     busy, out_valid, in_ready);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL %s: in_ready=%b out_valid=%b busy=%b out_data=%h required 1,0,0,00",
                     tag, in_ready, out_valid, busy, out_data);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; desc = 1'b0; out_ready = 1'b0;
        tick();
        check_reset_outputs("reset_during");
        n_tests++;
        if (cmp_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_cmp_count: cmp_count=%0d required 0", cmp_count);
        end
        tick();
        rst_n = 1'b1;
        tick();
        check_reset_outputs("reset_after");
    endtask

    task automatic test_basic();
        logic [7:0] q [$];
        q = {8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 8'd2, 8'd7, 8'd4};
        load_block(q, 1'b0, 1'b0);
        drain_block(1'b0);
    endtask

    task automatic test_sorted_inputs();
        logic [7:0] q [$];
        q = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load_block(q, 1'b0, 1'b0);
        drain_block(1'b0);
        n_tests++;
        if (cmp_count !== 8'd7) begin
            n_fail++;
            $display("FAIL sorted_cmp_count: cmp_count=%0d required 7", cmp_count);
        end
        n_tests++;
        if (first_valid != 8) begin
            n_fail++;
            $display("FAIL sorted_latency: first out_valid at cycle %0d required 8", first_valid);
        end
        q = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        load_block(q, 1'b0, 1'b0);
        drain_block(1'b0);
        n_tests++;
        if (cmp_count !== 8'd28) begin
            n_fail++;
            $display("FAIL reverse_cmp_count: cmp_count=%0d required 28", cmp_count);
        end
        n_tests++;
        if (first_valid != 29) begin
            n_fail++;
            $display("FAIL reverse_latency: first out_valid at cycle %0d required 29", first_valid);
        end
    endtask

    task automatic test_desc_unsigned();
        logic [7:0] q [$];
        q = {8'h00, 8'hFF, 8'h80, 8'h7F, 8'h80, 8'h01, 8'hFE, 8'h00};
        load_block(q, 1'b1, 1'b0);
        drain_block(1'b0);
    endtask

    task automatic test_random();
        for (int b = 0; b < 20; b++) begin
            logic [7:0] q [$];
            bit d;
            q.delete();
            for (int i = 0; i < int'(DEPTH); i++) q.push_back(8'($urandom_range(0, 255)));
            d = 1'($urandom_range(0, 1));
            load_block(q, d, 1'b1);
            drain_block(1'b1);
            n_tests++;
            if (cmp_count < 8'd7 || cmp_count > 8'd28) begin
                n_fail++;
                $display("FAIL random_cmp_count[%0d]: cmp_count=%0d required 7..28", b, cmp_count);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] q [$];
        // Reset after three loaded bytes.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hA0 + i);
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_load");
        tick();
        rst_n = 1'b1;
        tick();
        q = {8'd40, 8'd10, 8'd30, 8'd20, 8'd80, 8'd60, 8'd70, 8'd50};
        load_block(q, 1'b0, 1'b0);
        drain_block(1'b0);
        // Reset part-way through a long sort.
        q = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        load_block(q, 1'b0, 1'b0);
        repeat (5) tick();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_sort_busy: busy=%b required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_sort");
        n_tests++;
        if (cmp_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid_sort_cmp_count: cmp_count=%0d required 0", cmp_count);
        end
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        q = {8'd3, 8'd3, 8'd1, 8'd200, 8'd0, 8'd9, 8'd255, 8'd3};
        load_block(q, 1'b1, 1'b0);
        drain_block(1'b0);
    endtask

    task automatic test_equal();
        logic [7:0] q [$];
        q = {8'h42, 8'h42, 8'h42, 8'h42, 8'h42, 8'h42, 8'h42, 8'h42};
        load_block(q, 1'b0, 1'b0);
        drain_block(1'b1);
        n_tests++;
        if (cmp_count !== 8'd7) begin
            n_fail++;
            $display("FAIL equal_cmp_count: cmp_count=%0d required 7", cmp_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sorted_inputs();
        test_desc_unsigned();
        test_random();
        test_reset_mid();
        test_equal();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d expected bytes never drained, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
